// File: rtl/nubus_slot_master_pkg.sv
// Shared types and constants for the NuBus slot initiator.
package nubus_slot_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      RELEASE
   } state_e;

   localparam logic [3:0]  SLOT_SPACE_PREFIX = 4'hF;
   localparam int unsigned DEFAULT_TIMEOUT   = 1024;

   function automatic logic [31:0] slot_addr(input logic [3:0] slot, input logic [23:0] offset);
      return {SLOT_SPACE_PREFIX, slot, offset};
   endfunction

endpackage

// File: rtl/nubus_slot_master_if.sv
// CPU-side request/response and card-side select/ack signals for one slot.
interface nubus_slot_master_if;

   logic        cpu_req;
   logic        cpu_rw_n;
   logic [1:0]  cpu_uds_lds;
   logic [23:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_berr;
   logic        cpu_busy;

   logic [31:0] nb_addr;
   logic [15:0] nb_wdata;
   logic [15:0] nb_rdata;
   logic [1:0]  nb_uds_lds;
   logic        nb_rw_n;
   logic        nb_select;
   logic        nb_ack_n;
   logic        nb_nmrq_n;

   logic        slot_irq;
   logic        slot_irq_rise;

   modport master (
      input  cpu_req, cpu_rw_n, cpu_uds_lds, cpu_addr, cpu_wdata,
      input  nb_rdata, nb_ack_n, nb_nmrq_n,
      output cpu_rdata, cpu_done, cpu_berr, cpu_busy,
      output nb_addr, nb_wdata, nb_uds_lds, nb_rw_n, nb_select,
      output slot_irq, slot_irq_rise
   );

   modport slave (
      output cpu_req, cpu_rw_n, cpu_uds_lds, cpu_addr, cpu_wdata,
      output nb_rdata, nb_ack_n, nb_nmrq_n,
      input  cpu_rdata, cpu_done, cpu_berr, cpu_busy,
      input  nb_addr, nb_wdata, nb_uds_lds, nb_rw_n, nb_select,
      input  slot_irq, slot_irq_rise
   );

endinterface

// File: rtl/nubus_slot_master_irq_sync.sv
// Two-flop synchroniser for a card's nmrq_n, with registered active-high level and rise pulse.
module nubus_irq_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic nmrq_n_i,
   output logic irq_o,
   output logic irq_rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic irq_q;
   logic irq_rise_q;
   logic irq_d;

   assign irq_d = ~sync2_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         irq_q      <= 1'b0;
         irq_rise_q <= 1'b0;
      end else begin
         sync1_q    <= nmrq_n_i;
         sync2_q    <= sync1_q;
         irq_q      <= irq_d;
         irq_rise_q <= irq_d & ~irq_q;
      end
   end

   assign irq_o      = irq_q;
   assign irq_rise_o = irq_rise_q;

endmodule

// File: rtl/nubus_slot_master.sv
// Host-side NuBus slot initiator: turns a single CPU slot-space access into a
// select/ack_n handshake with one card, with ack timeout and interrupt sync.
module nubus_slot_master
   import nubus_slot_master_pkg::*;
#(
   parameter logic [3:0]  SLOT_ID = 4'h9,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input logic                  clk,
   input logic                  reset,
   nubus_slot_master_if.master  bus
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_e      state_q;
   logic [15:0] cnt_q;
   logic [31:0] nb_addr_q;
   logic [15:0] nb_wdata_q;
   logic [1:0]  nb_uds_lds_q;
   logic        nb_rw_n_q;
   logic        nb_select_q;
   logic [15:0] cpu_rdata_q;
   logic        cpu_done_q;
   logic        cpu_berr_q;
   logic        cpu_busy_q;
   logic        irq;
   logic        irq_rise;

   always_ff @(posedge clk) begin
      cpu_done_q <= 1'b0;
      cpu_berr_q <= 1'b0;
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         nb_addr_q    <= '0;
         nb_wdata_q   <= '0;
         nb_uds_lds_q <= '0;
         nb_rw_n_q    <= 1'b1;
         nb_select_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.cpu_req && bus.nb_ack_n) begin
                  nb_addr_q    <= slot_addr(SLOT_ID, bus.cpu_addr);
                  nb_wdata_q   <= bus.cpu_wdata;
                  nb_uds_lds_q <= bus.cpu_uds_lds;
                  nb_rw_n_q    <= bus.cpu_rw_n;
                  nb_select_q  <= 1'b1;
                  cpu_busy_q   <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= DRIVE;
               end
            end
            DRIVE: begin
               // Ack is tested first so it wins over a coincident timeout.
               if (!bus.nb_ack_n) begin
                  if (nb_rw_n_q) cpu_rdata_q <= bus.nb_rdata;
                  cpu_done_q  <= 1'b1;
                  nb_select_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= RELEASE;
               end else if (cnt_q == CNT_LAST) begin
                  cpu_berr_q  <= 1'b1;
                  nb_select_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= RELEASE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RELEASE: begin
               if (bus.nb_ack_n || cnt_q == CNT_LAST) begin
                  cpu_busy_q <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   nubus_irq_sync u_irq_sync (
      .clk_i      (clk),
      .reset_i    (reset),
      .nmrq_n_i   (bus.nb_nmrq_n),
      .irq_o      (irq),
      .irq_rise_o (irq_rise)
   );

   assign bus.nb_addr       = nb_addr_q;
   assign bus.nb_wdata      = nb_wdata_q;
   assign bus.nb_uds_lds    = nb_uds_lds_q;
   assign bus.nb_rw_n       = nb_rw_n_q;
   assign bus.nb_select     = nb_select_q;
   assign bus.cpu_rdata     = cpu_rdata_q;
   assign bus.cpu_done      = cpu_done_q;
   assign bus.cpu_berr      = cpu_berr_q;
   assign bus.cpu_busy      = cpu_busy_q;
   assign bus.slot_irq      = irq;
   assign bus.slot_irq_rise = irq_rise;

endmodule

// File: tb/tb_nubus_slot_master.sv
// Directed bench for nubus_slot_master: scoreboard of expected done/berr responses
// plus direct timing checks against a behavioural slot card.
module tb_nubus_slot_master;

   localparam int unsigned TB_TIMEOUT = 24;
   localparam logic [3:0]  TB_SLOT    = 4'h9;
   localparam int          WAIT_MAX   = 200;

   typedef struct packed {
      logic        berr;
      logic [15:0] rdata;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   nubus_slot_master_if bus();

   nubus_slot_master #(.SLOT_ID(TB_SLOT), .TIMEOUT(TB_TIMEOUT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic [15:0] last_rd = 16'h0000;

   // Behavioural card: acks card_lat cycles after seeing select, releases when select drops.
   logic        card_ack_n  = 1'b1;
   logic [15:0] card_data   = 16'h0000;
   logic        card_noack  = 1'b0;
   logic        card_stuck  = 1'b0;
   int          card_lat    = 0;
   int          card_cnt    = 0;
   logic        nmrq_n      = 1'b1;

   assign bus.nb_ack_n  = card_ack_n;
   assign bus.nb_rdata  = card_data;
   assign bus.nb_nmrq_n = nmrq_n;

   always @(posedge clk) begin
      if (bus.nb_select) begin
         if (card_cnt == card_lat && !card_noack) card_ack_n <= 1'b0;
         card_cnt <= card_cnt + 1;
      end else begin
         card_cnt <= 0;
         if (!card_stuck) card_ack_n <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.cpu_done || bus.cpu_berr) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_berr", {31'd0, bus.cpu_berr}, {31'd0, e.berr});
            check("resp_done", {31'd0, bus.cpu_done}, {31'd0, ~e.berr});
            check("resp_rdata", {16'd0, bus.cpu_rdata}, {16'd0, e.rdata});
         end
      end
   end

   task automatic run_access(input logic rw, input logic [23:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input logic exp_berr,
                             output int t_acc, output int t_resp, output int t_idle);
      exp_t e;
      logic bad;
      logic [31:0] exp_addr;
      e.berr  = exp_berr;
      e.rdata = (rw && !exp_berr) ? card_data : last_rd;
      last_rd = e.rdata;
      sb.push_back(e);
      exp_addr = {4'hF, TB_SLOT, addr};
      bus.cpu_rw_n    = rw;
      bus.cpu_addr    = addr;
      bus.cpu_wdata   = wd;
      bus.cpu_uds_lds = be;
      bus.cpu_req     = 1'b1;
      t_acc = 0;
      do begin
         @(negedge clk);
         t_acc++;
      end while (!bus.cpu_busy && t_acc < WAIT_MAX);
      check("accepted", {31'd0, bus.cpu_busy}, 32'd1);
      check("nb_addr", bus.nb_addr, exp_addr);
      check("nb_ctrl", {12'd0, bus.nb_select, bus.nb_rw_n, bus.nb_uds_lds, bus.nb_wdata},
            {12'd0, 1'b1, rw, be, wd});
      bad = 1'b0;
      t_resp = 0;
      do begin
         @(negedge clk);
         t_resp++;
         if (!bus.cpu_done && !bus.cpu_berr &&
             (bus.nb_select !== 1'b1 || bus.nb_addr !== exp_addr || bus.nb_wdata !== wd ||
              bus.nb_uds_lds !== be || bus.nb_rw_n !== rw))
            bad = 1'b1;
      end while (!(bus.cpu_done || bus.cpu_berr) && t_resp < WAIT_MAX);
      check("hold_stable", {31'd0, bad}, 32'd0);
      check("sel_at_resp", {31'd0, bus.nb_select}, 32'd0);
      bus.cpu_req = 1'b0;
      t_idle = t_resp;
      do begin
         @(negedge clk);
         t_idle++;
      end while (bus.cpu_busy && t_idle < WAIT_MAX);
      check("idle_reached", {31'd0, bus.cpu_busy}, 32'd0);
   endtask

   initial begin
      int ta, tr, ti, cnt, lat, rises;
      bus.cpu_req     = 1'b0;
      bus.cpu_rw_n    = 1'b1;
      bus.cpu_addr    = '0;
      bus.cpu_wdata   = '0;
      bus.cpu_uds_lds = '0;

      repeat (3) @(negedge clk);
      check("rst_outputs", {bus.nb_addr[15:0], bus.cpu_rdata},
            32'h0000_0000);
      check("rst_ctrl", {26'd0, bus.nb_select, bus.nb_rw_n, bus.cpu_busy, bus.cpu_done,
                         bus.cpu_berr, bus.slot_irq}, {26'd0, 6'b010000});
      reset = 1'b0;
      @(negedge clk);

      // Single-cycle-ack read.
      card_data = 16'hA55A;
      card_lat  = 0;
      run_access(1'b1, 24'h080008, 16'h0000, 2'b11, 1'b0, ta, tr, ti);
      check("rd_accept_lat", ta, 1);
      check("rd_resp_lat", tr, 2);
      check("rd_idle_lat", ti, 4);

      // Write with 20 cycles of card wait.
      card_lat = 19;
      run_access(1'b0, 24'h000100, 16'h1234, 2'b10, 1'b0, ta, tr, ti);
      check("wr_resp_lat", tr, 21);
      check("wr_idle_lat", ti, 23);

      // Card never acks.
      card_noack = 1'b1;
      run_access(1'b1, 24'h00FFFE, 16'h0000, 2'b01, 1'b1, ta, tr, ti);
      check("to_berr_lat", tr, TB_TIMEOUT);
      check("to_idle_lat", ti, TB_TIMEOUT + 1);
      card_noack = 1'b0;

      // Card keeps ack_n low after select drops.
      card_lat   = 0;
      card_stuck = 1'b1;
      card_data  = 16'h0F0F;
      run_access(1'b1, 24'h123456, 16'h0000, 2'b11, 1'b0, ta, tr, ti);
      check("stuck_idle_lat", ti, TB_TIMEOUT + 2);
      bus.cpu_req = 1'b1;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.cpu_busy || bus.nb_select) cnt++;
      end
      check("stuck_no_accept", cnt, 0);
      card_stuck = 1'b0;
      card_data  = 16'h7E81;
      run_access(1'b1, 24'h000002, 16'h0000, 2'b11, 1'b0, ta, tr, ti);
      check("stuck_accept_lat", ta, 2);

      // Reset three cycles into DRIVE.
      card_noack      = 1'b1;
      bus.cpu_rw_n    = 1'b0;
      bus.cpu_addr    = 24'hABCDEF;
      bus.cpu_wdata   = 16'hBEEF;
      bus.cpu_uds_lds = 2'b11;
      bus.cpu_req     = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.cpu_busy && cnt < WAIT_MAX);
      check("rstd_accepted", {31'd0, bus.cpu_busy}, 32'd1);
      repeat (3) @(negedge clk);
      reset       = 1'b1;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      check("rstd_addr", bus.nb_addr, 32'h0);
      check("rstd_data", {bus.nb_wdata, bus.cpu_rdata}, 32'h0);
      check("rstd_ctrl", {25'd0, bus.nb_select, bus.nb_rw_n, bus.nb_uds_lds, bus.cpu_busy,
                          bus.cpu_done, bus.cpu_berr}, {25'd0, 7'b0100000});
      last_rd    = 16'h0000;
      reset      = 1'b0;
      card_noack = 1'b0;
      repeat (2) @(negedge clk);

      // Interrupt assert then deassert.
      nmrq_n = 1'b0;
      lat = 0;
      rises = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.slot_irq && lat == 0) lat = k;
         if (bus.slot_irq_rise) rises++;
      end
      check("irq_set_lat", lat, 3);
      check("irq_rise_pulses", rises, 1);
      nmrq_n = 1'b1;
      lat = 0;
      rises = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (!bus.slot_irq && lat == 0) lat = k;
         if (bus.slot_irq_rise) rises++;
      end
      check("irq_clr_lat", lat, 3);
      check("irq_fall_pulses", rises, 0);

      repeat (3) @(negedge clk);
      check("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
